// File: rtl/div_signed_unsigned.sv
// div_signed_unsigned
// Iterative 32-bit divider, restoring shift-subtract, one quotient bit per
// cycle. SIGNED selects two's-complement (1) or unsigned (0) operation.
// The result {quotient, remainder} appears LATENCY edges after the accept
// edge as a one-cycle strobe; tdata/tuser hold until the next result.
// LATENCY must be 34 or greater: capture (edge N), setup (N+1), 32
// iterations (N+2..N+33), and the sign fix-up registered on edge N+LATENCY.
module div_signed_unsigned #(
   parameter bit SIGNED  = 1'b1,
   parameter int LATENCY = 36
) (
   input  logic        aclk,
   input  logic        aresetn,
   input  logic        s_axis_dividend_tvalid,
   output logic        s_axis_dividend_tready,
   input  logic [31:0] s_axis_dividend_tdata,
   input  logic        s_axis_divisor_tvalid,
   output logic        s_axis_divisor_tready,
   input  logic [31:0] s_axis_divisor_tdata,
   output logic        m_axis_dout_tvalid,
   output logic        m_axis_dout_tuser,
   output logic [63:0] m_axis_dout_tdata
);

   localparam int CW = $clog2(LATENCY + 1);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t        state;
   logic [CW-1:0] cnt;        // edges elapsed since the accept edge
   logic          ready_q;
   logic [31:0]   a_q, b_q;   // captured operands
   logic          neg_a_q;    // dividend negative (signed mode only)
   logic          neg_q_q;    // quotient must be negated
   logic          dbz_q;      // divisor was zero
   logic [31:0]   dvs;        // divisor magnitude
   logic [31:0]   rem;        // partial remainder
   logic [31:0]   quo;        // dividend shifts out, quotient shifts in

   logic          both_valid;
   logic          neg_a, neg_b;
   logic [31:0]   mag_a, mag_b;
   logic [32:0]   trial;
   logic [31:0]   fix_q, fix_r;

   assign both_valid             = s_axis_dividend_tvalid && s_axis_divisor_tvalid;
   assign s_axis_dividend_tready = ready_q;
   assign s_axis_divisor_tready  = ready_q;

   // Magnitudes, trial subtraction and sign fix-up of the final result.
   // 0x80000000 negates to itself, which is its correct unsigned magnitude.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      neg_a = 1'b0;
      neg_b = 1'b0;
      if (SIGNED) begin
         neg_a = a_q[31];
         neg_b = b_q[31];
      end
      mag_a = neg_a ? (~a_q + 32'd1) : a_q;
      mag_b = neg_b ? (~b_q + 32'd1) : b_q;
      trial = {rem, quo[31]} - {1'b0, dvs};
      fix_q = neg_q_q ? (~quo + 32'd1) : quo;
      fix_r = neg_a_q ? (~rem + 32'd1) : rem;
   end

   // Control FSM, divider datapath and registered result channel.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         // NOTE: working registers are reset with the rest so an aborted operation leaves no stale state behind.
         state              <= IDLE;
         cnt                <= '0;
         ready_q            <= 1'b0;
         a_q                <= '0;
         b_q                <= '0;
         neg_a_q            <= 1'b0;
         neg_q_q            <= 1'b0;
         dbz_q              <= 1'b0;
         dvs                <= '0;
         rem                <= '0;
         quo                <= '0;
         m_axis_dout_tvalid <= 1'b0;
         m_axis_dout_tuser  <= 1'b0;
         m_axis_dout_tdata  <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         m_axis_dout_tvalid <= 1'b0;
         case (state)
            IDLE: begin
               if (ready_q && both_valid) begin
                  a_q     <= s_axis_dividend_tdata;
                  b_q     <= s_axis_divisor_tdata;
                  cnt     <= CW'(1);
                  ready_q <= 1'b0;
                  state   <= BUSY;
               end else begin
                  ready_q <= 1'b1;
               end
            end
            BUSY: begin
               cnt <= cnt + CW'(1);
               if (cnt == CW'(1)) begin
                  // setup: magnitudes and result signs
                  rem     <= '0;
                  quo     <= mag_a;
                  dvs     <= mag_b;
                  neg_a_q <= neg_a;
                  neg_q_q <= neg_a ^ neg_b;
                  dbz_q   <= (b_q == 32'd0);
               end else if (cnt >= CW'(2) && cnt <= CW'(33)) begin
                  // one restoring step
                  if (!trial[32]) begin
                     rem <= trial[31:0];
                     quo <= {quo[30:0], 1'b1};
                  end else begin
                     rem <= {rem[30:0], quo[31]};
                     quo <= {quo[30:0], 1'b0};
                  end
               end
               if (cnt == CW'(LATENCY)) begin
                  m_axis_dout_tvalid <= 1'b1;
                  m_axis_dout_tuser  <= dbz_q;
                  m_axis_dout_tdata  <= {fix_q, fix_r};
                  if (both_valid) begin
                     // operands held valid: start the next operation at once
                     a_q <= s_axis_dividend_tdata;
                     b_q <= s_axis_divisor_tdata;
                     cnt <= CW'(1);
                  end else begin
                     ready_q <= 1'b1;
                     state   <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_div_signed_unsigned.sv
// Directed bench for div_signed_unsigned: one unsigned and one signed
// instance share the clock, reset and operand data; each has its own valids.
module tb_div_signed_unsigned;

   logic        aclk = 1'b0;
   logic        aresetn = 1'b0;
   logic [31:0] div_tdata = '0;
   logic [31:0] dvs_tdata = '0;
   logic        u_va = 1'b0, u_vb = 1'b0, s_va = 1'b0, s_vb = 1'b0;
   logic        u_ra, u_rb, s_ra, s_rb;
   logic        u_tv, s_tv, u_tu, s_tu;
   logic [63:0] u_td, s_td;

   int tests = 0;
   int fails = 0;

   always #5 aclk = ~aclk;

   div_signed_unsigned #(.SIGNED(1'b0), .LATENCY(36)) u_divu (
      .aclk(aclk), .aresetn(aresetn),
      .s_axis_dividend_tvalid(u_va), .s_axis_dividend_tready(u_ra),
      .s_axis_dividend_tdata(div_tdata),
      .s_axis_divisor_tvalid(u_vb), .s_axis_divisor_tready(u_rb),
      .s_axis_divisor_tdata(dvs_tdata),
      .m_axis_dout_tvalid(u_tv), .m_axis_dout_tuser(u_tu),
      .m_axis_dout_tdata(u_td)
   );

   div_signed_unsigned #(.SIGNED(1'b1), .LATENCY(36)) u_divs (
      .aclk(aclk), .aresetn(aresetn),
      .s_axis_dividend_tvalid(s_va), .s_axis_dividend_tready(s_ra),
      .s_axis_dividend_tdata(div_tdata),
      .s_axis_divisor_tvalid(s_vb), .s_axis_divisor_tready(s_rb),
      .s_axis_divisor_tdata(dvs_tdata),
      .m_axis_dout_tvalid(s_tv), .m_axis_dout_tuser(s_tu),
      .m_axis_dout_tdata(s_td)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %h, want %h", tag, obs, exp);
      end
   endtask

   // One operation on the selected instance; accept edge is k=0, outputs
   // sampled 1 time unit after each following edge.
   task automatic run_op(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eq, input logic [31:0] er, input logic eu,
                         input string tag);
      int          hit_k  = -1;
      int          pulses = 0;
      logic [63:0] d      = 'x;
      logic        u      = 1'bx;
      logic        busy_rdy = 1'bx;
      div_tdata = a;
      dvs_tdata = b;
      if (sgn) begin s_va = 1'b1; s_vb = 1'b1; end
      else     begin u_va = 1'b1; u_vb = 1'b1; end
      @(posedge aclk); #1;
      u_va = 1'b0; u_vb = 1'b0; s_va = 1'b0; s_vb = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         @(posedge aclk); #1;
         if (sgn ? s_tv : u_tv) begin
            pulses++;
            if (hit_k < 0) begin
               hit_k = k;
               d = sgn ? s_td : u_td;
               u = sgn ? s_tu : u_tu;
            end
         end
         if (k == 10) busy_rdy = sgn ? (s_ra | s_rb) : (u_ra | u_rb);
      end
      check({tag, " latency"}, 64'(hit_k), 64'd36);
      check({tag, " pulses"}, 64'(pulses), 64'd1);
      check({tag, " tdata"}, d, {eq, er});
      check({tag, " tuser"}, {63'd0, u}, {63'd0, eu});
      check({tag, " busy tready"}, {63'd0, busy_rdy}, 64'd0);
   endtask

   initial begin : main
      int          k1, k2, k3, np, rdy_err, tv_cnt;
      logic [63:0] d1, d2, d3;

      // reset state
      #3;
      check("rst u_tready", {62'd0, u_ra, u_rb}, 64'd0);
      check("rst s_tready", {62'd0, s_ra, s_rb}, 64'd0);
      check("rst outputs", {u_tv, u_tu, s_tv, s_tu}, 64'd0);
      check("rst tdata", u_td | s_td, 64'd0);
      repeat (2) @(posedge aclk);
      #1 aresetn = 1'b1;
      @(posedge aclk); #1;
      check("post-rst tready", {60'd0, u_ra, u_rb, s_ra, s_rb}, 64'hF);

      // unsigned
      run_op(1'b0, 32'd100,        32'd7,        32'h0000000E, 32'h00000002, 1'b0, "u 100/7");
      run_op(1'b0, 32'hFFFFFFFF,   32'h10,       32'h0FFFFFFF, 32'h0000000F, 1'b0, "u ffffffff/16");
      run_op(1'b0, 32'hFFFFFFF9,   32'd2,        32'h7FFFFFFC, 32'h00000001, 1'b0, "u fffffff9/2");
      run_op(1'b0, 32'h80000000,   32'd1,        32'h80000000, 32'h00000000, 1'b0, "u 80000000/1");
      run_op(1'b0, 32'd5,          32'd0,        32'hFFFFFFFF, 32'h00000005, 1'b1, "u 5/0");
      // signed
      run_op(1'b1, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, "s -7/2");
      run_op(1'b1, 32'd7,          32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000001, 1'b0, "s 7/-2");
      run_op(1'b1, 32'hFFFFFFF9,   32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 1'b0, "s -7/-2");
      run_op(1'b1, 32'd100,        32'd7,        32'h0000000E, 32'h00000002, 1'b0, "s 100/7");
      run_op(1'b1, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, 32'h00000000, 1'b0, "s min/-1");
      run_op(1'b1, 32'hFFFFFFFB,   32'd0,        32'h00000001, 32'hFFFFFFFB, 1'b1, "s -5/0");
      run_op(1'b1, 32'd5,          32'd0,        32'hFFFFFFFF, 32'h00000005, 1'b1, "s 5/0");

      // only one tvalid: no accept, tready stays high, no result
      div_tdata = 32'd9; dvs_tdata = 32'd3;
      u_va = 1'b1;
      rdy_err = 0; tv_cnt = 0;
      for (int k = 0; k < 40; k++) begin
         @(posedge aclk); #1;
         if (!(u_ra && u_rb)) rdy_err++;
         if (u_tv) tv_cnt++;
      end
      u_va = 1'b0;
      check("half valid tready", 64'(rdy_err), 64'd0);
      check("half valid no result", 64'(tv_cnt), 64'd0);

      // back-to-back: valids held for 80 cycles, operands change while busy
      div_tdata = 32'd100; dvs_tdata = 32'd7;
      u_va = 1'b1; u_vb = 1'b1;
      @(posedge aclk); #1;
      k1 = -1; k2 = -1; k3 = -1; np = 0; rdy_err = 0;
      d1 = '0; d2 = '0; d3 = '0;
      for (int k = 1; k <= 120; k++) begin
         @(posedge aclk); #1;
         if (k == 5) begin div_tdata = 32'd1000; dvs_tdata = 32'd10; end
         if (k == 80) begin u_va = 1'b0; u_vb = 1'b0; end
         if (k <= 35 && (u_ra || u_rb)) rdy_err++;
         if (u_tv) begin
            np++;
            if (np == 1) begin k1 = k; d1 = u_td; end
            if (np == 2) begin k2 = k; d2 = u_td; end
            if (np == 3) begin k3 = k; d3 = u_td; end
         end
      end
      check("b2b first at", 64'(k1), 64'd36);
      check("b2b first data", d1, {32'h0000000E, 32'h00000002});
      check("b2b second at", 64'(k2), 64'd72);
      check("b2b second data", d2, {32'h00000064, 32'h00000000});
      check("b2b third at", 64'(k3), 64'd108);
      check("b2b third data", d3, {32'h00000064, 32'h00000000});
      check("b2b pulses", 64'(np), 64'd3);
      check("b2b busy tready", 64'(rdy_err), 64'd0);

      // reset mid-operation aborts it
      div_tdata = 32'hFFFFFFFB; dvs_tdata = 32'd0;
      s_va = 1'b1; s_vb = 1'b1;
      @(posedge aclk); #1;
      s_va = 1'b0; s_vb = 1'b0;
      repeat (10) @(posedge aclk);
      #2 aresetn = 1'b0;
      #1;
      check("abort outputs", {60'd0, s_tv, s_tu, s_ra, s_rb}, 64'd0);
      check("abort tdata", s_td, 64'd0);
      repeat (3) @(posedge aclk);
      #1 aresetn = 1'b1;
      tv_cnt = 0;
      for (int k = 0; k < 40; k++) begin
         @(posedge aclk); #1;
         if (s_tv) tv_cnt++;
      end
      check("abort no result", 64'(tv_cnt), 64'd0);
      run_op(1'b1, 32'hFFFFFFFB, 32'd0, 32'h00000001, 32'hFFFFFFFB, 1'b1, "s after reset");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
